switchover_sequencer: RTL and testbench

Sequences host handover between CPU A and CPU B. Produces the `switch` select that drives the output_switch muxes, and the reset_A/reset_B lines.
Inputs are the pulse-detector health signals (io_a/io_b) and the decoded switch commands from the command block.
It debounces health, applies auto-failover and commanded switches, and enforces a reset phase and a guard phase after each handover.
It sits between command/pulse_detection and the switch/reset pins.

---
 rtl/switchover_sequencer_pkg.sv | 28 ++
 rtl/switchover_sequencer_health.sv | 33 +++
 rtl/switchover_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_switchover_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switchover_sequencer_pkg.sv
// switchover_sequencer_pkg: shared types and defaults for the
// host switchover sequencer (state and host encodings, cycle constants).
package switchover_sequencer_pkg;

    typedef enum logic [1:0] {
        S_HOST  = 2'd0,
        S_RESET = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    localparam logic HOST_A = 1'b0;
    localparam logic HOST_B = 1'b1;

    localparam int DEF_DEBOUNCE_CYC = 1000;
    localparam int DEF_RESET_CYC    = 10000;
    localparam int DEF_GUARD_CYC    = 50000;
    localparam int DEF_CNT_W        = 20;

    // Health of the CPU selected by `host` out of the pair {b, a}.
    function automatic logic pick_health(
        input logic host,
        input logic health_a,
        input logic health_b
    );
        return (host == HOST_B) ? health_b : health_a;
    endfunction

endpackage

// File: rtl/switchover_sequencer_health.sv
// health_filter: debounces one raw heartbeat-healthy level.
// Ports: clk, rst (sync, active-high), raw_in, filt_out (resets to 1).
module health_filter
    import switchover_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic filt_out
);

    logic [CNT_W-1:0] cnt_q;

    // The count is the current run length of disagreement; any
    // agreeing sample restarts it, so only an unbroken run flips.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_out <= 1'b1;
            cnt_q    <= '0;
        end else if (raw_in == filt_out) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            filt_out <= raw_in;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/switchover_sequencer.sv
// switchover_sequencer: sequences host handover between CPU A and B.
// Debounces health, applies auto-failover and commanded switches,
// and enforces a reset phase and a guard phase after each handover.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   io_a, io_b        raw heartbeat-healthy levels of CPU A / CPU B
//   force_swi         level: disables auto-failover, allows commands
//                     to an unhealthy target
//   com_swi           one-cycle command strobe
//   com_target        requested host for com_swi (0=A, 1=B)
//   switch            current host (0=A, 1=B)
//   reset_A, reset_B  active-high resets to the CPUs
//   busy              high in the reset or guard phase
//   fault             both filtered health values are 0
//   swi_event         one-cycle pulse when switch changes
//   cmd_reject        one-cycle pulse when com_swi is refused
//   swi_count         saturating handover count (SWI_COUNT_EN only)
//
// Build option: define SWI_COUNT_EN to add the swi_count output.
module switchover_sequencer
    import switchover_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int RESET_CYC    = DEF_RESET_CYC,
    parameter int GUARD_CYC    = DEF_GUARD_CYC,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_a,
    input  logic       io_b,
    input  logic       force_swi,
    input  logic       com_swi,
    input  logic       com_target,
    output logic       switch,
    output logic       reset_A,
    output logic       reset_B,
    output logic       busy,
    output logic       fault,
    output logic       swi_event,
    output logic       cmd_reject
`ifdef SWI_COUNT_EN
    ,
    output logic [7:0] swi_count
`endif
);

    logic filt_a;
    logic filt_b;

    health_filter #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .CNT_W       (CNT_W)
    ) u_filt_a (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (io_a),
        .filt_out(filt_a)
    );

    health_filter #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .CNT_W       (CNT_W)
    ) u_filt_b (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (io_b),
        .filt_out(filt_b)
    );

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             switch_d;
    logic             reset_a_d;
    logic             reset_b_d;
    logic             swi_event_d;
    logic             cmd_reject_d;

    logic hf;
    logic sf;
    logic cmd_diff;
    logic cmd_ok;
    logic cmd_bad;
    logic auto_fo;
    logic take;

    assign hf = pick_health(switch, filt_a, filt_b);
    assign sf = pick_health(~switch, filt_a, filt_b);

    // Decision terms for the host state; the rejected command and the
    // take condition are mutually exclusive because a reject needs sf=0.
    assign cmd_diff = com_swi & (com_target != switch);
    assign cmd_ok   = cmd_diff & (sf | force_swi);
    assign cmd_bad  = cmd_diff & ~(sf | force_swi);
    assign auto_fo  = ~force_swi & ~hf & sf;
    assign take     = cmd_ok | auto_fo;

    assign busy = (state_q != S_HOST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        switch_d     = switch;
        reset_a_d    = reset_A;
        reset_b_d    = reset_B;
        swi_event_d  = 1'b0;
        cmd_reject_d = 1'b0;

        unique case (state_q)
            S_HOST: begin
                cnt_d = '0;
                unique case (1'b1)
                    cmd_bad: begin
                        cmd_reject_d = 1'b1;
                    end
                    take: begin
                        switch_d    = ~switch;
                        swi_event_d = 1'b1;
                        // An unhealthy old host is held in reset
                        // before the guard window starts.
                        if (!hf) begin
                            state_d = S_RESET;
                            if (switch == HOST_A) begin
                                reset_a_d = 1'b1;
                            end else begin
                                reset_b_d = 1'b1;
                            end
                        end else begin
                            state_d = S_GUARD;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            S_RESET: begin
                cmd_reject_d = com_swi;
                if (cnt_q == CNT_W'(RESET_CYC - 1)) begin
                    state_d   = S_GUARD;
                    cnt_d     = '0;
                    reset_a_d = 1'b0;
                    reset_b_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GUARD: begin
                cmd_reject_d = com_swi;
                if (cnt_q == CNT_W'(GUARD_CYC - 1)) begin
                    state_d = S_HOST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_HOST;
                cnt_d     = '0;
                reset_a_d = 1'b0;
                reset_b_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HOST;
            cnt_q      <= '0;
            switch     <= HOST_A;
            reset_A    <= 1'b0;
            reset_B    <= 1'b0;
            swi_event  <= 1'b0;
            cmd_reject <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            switch     <= switch_d;
            reset_A    <= reset_a_d;
            reset_B    <= reset_b_d;
            swi_event  <= swi_event_d;
            cmd_reject <= cmd_reject_d;
            fault      <= ~filt_a & ~filt_b;
        end
    end

`ifdef SWI_COUNT_EN
    // Updated alongside swi_event so both are visible on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            swi_count <= 8'd0;
        end else if (swi_event_d && (swi_count != 8'hFF)) begin
            swi_count <= swi_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_switchover_sequencer.sv
// tb_switchover_sequencer: randomized and directed bench for
// switchover_sequencer, checked against a timeline reference model.
module tb_switchover_sequencer;

    localparam int DEB   = 4;
    localparam int RCYC  = 8;
    localparam int GCYC  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic io_a = 1'b1;
    logic io_b = 1'b1;
    logic force_swi = 1'b0;
    logic com_swi = 1'b0;
    logic com_target = 1'b0;
    logic switch;
    logic reset_A;
    logic reset_B;
    logic busy;
    logic fault;
    logic swi_event;
    logic cmd_reject;
`ifdef SWI_COUNT_EN
    logic [7:0] swi_count;
`endif

    always #5 clk = ~clk;

    switchover_sequencer #(
        .DEBOUNCE_CYC(DEB),
        .RESET_CYC   (RCYC),
        .GUARD_CYC   (GCYC),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .io_a      (io_a),
        .io_b      (io_b),
        .force_swi (force_swi),
        .com_swi   (com_swi),
        .com_target(com_target),
        .switch    (switch),
        .reset_A   (reset_A),
        .reset_B   (reset_B),
        .busy      (busy),
        .fault     (fault),
        .swi_event (swi_event),
        .cmd_reject(cmd_reject)
`ifdef SWI_COUNT_EN
        ,
        .swi_count (swi_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: handovers are recorded as absolute cycle
    // windows; health is the last DEB raw samples held in a bit history.
    int          cyc = 0;
    int          busy_end = -1;
    int          reset_end = -1;
    logic        m_host = 1'b0;
    logic        m_rwho = 1'b0;
    logic [1:0]  m_filt = 2'b11;
    logic        m_fault = 1'b0;
    logic        m_evt = 1'b0;
    logic        m_rej = 1'b0;
    int          m_cnt = 0;
    logic [31:0] hist [2];
    int          nvalid [2];

    task automatic model_step();
        int n;
        logic hf, sf, busy_now, dif, bad, take, raw;
        logic [31:0] mask;
        n = cyc;
        cyc++;
        if (rst) begin
            m_host = 1'b0; busy_end = -1; reset_end = -1;
            m_fault = 1'b0; m_evt = 1'b0; m_rej = 1'b0; m_cnt = 0;
            m_filt = 2'b11;
            for (int i = 0; i < 2; i++) begin
                hist[i] = '0; nvalid[i] = 0;
            end
            return;
        end
        hf = m_filt[m_host];
        sf = m_filt[~m_host];
        busy_now = (n <= busy_end);
        dif  = com_swi && (com_target != m_host);
        bad  = com_swi && (busy_now || (dif && !(sf || force_swi)));
        take = !busy_now &&
               ((dif && (sf || force_swi)) || (!force_swi && !hf && sf));
        m_rej = bad;
        m_evt = take;
        m_fault = !m_filt[0] && !m_filt[1];
        if (take) begin
            m_rwho = m_host;
            reset_end = hf ? -1 : n + RCYC;
            busy_end = n + (hf ? 0 : RCYC) + GCYC;
            m_host = ~m_host;
            if (m_cnt < 255) m_cnt++;
        end
        mask = (32'd1 << DEB) - 32'd1;
        for (int i = 0; i < 2; i++) begin
            raw = (i == 0) ? io_a : io_b;
            hist[i] = {hist[i][30:0], raw};
            if (nvalid[i] < 32) nvalid[i]++;
            if (nvalid[i] >= DEB &&
                (hist[i] & mask) == (m_filt[i] ? 32'd0 : mask)) begin
                m_filt[i] = ~m_filt[i];
                nvalid[i] = 0;
            end
        end
    endtask

    function automatic logic [6:0] model_outs();
        logic ra, rb, bz;
        ra = (cyc <= reset_end) && (m_rwho == 1'b0);
        rb = (cyc <= reset_end) && (m_rwho == 1'b1);
        bz = (cyc <= busy_end);
        return {m_host, ra, rb, bz, m_fault, m_evt, m_rej};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("outs", {switch, reset_A, reset_B, busy, fault,
                     swi_event, cmd_reject}, model_outs());
`ifdef SWI_COUNT_EN
        chk("swi_count", swi_count, m_cnt);
`endif
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic do_reset();
        io_a = 1'b1; io_b = 1'b1; force_swi = 1'b0;
        com_swi = 1'b0; com_target = 1'b0;
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
    endtask

    task automatic command(input logic tgt);
        com_swi = 1'b1; com_target = tgt;
        step();
        com_swi = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 64) begin
            step();
            k++;
        end
        chk("idle_wait", busy, 1'b0);
    endtask

    initial begin
        int ev_at, n_ra, n_bz, last_bz, n_ev;

        do_reset();
        chk("rst_vals", {switch, reset_A, reset_B, busy, fault,
                         swi_event, cmd_reject}, 7'd0);

        // 1: failover from A after io_a drops
        io_a = 1'b0;
        ev_at = 0; n_ra = 0; n_bz = 0; last_bz = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (swi_event && ev_at == 0) ev_at = k;
            if (reset_A) n_ra++;
            if (busy) begin
                n_bz++;
                last_bz = k;
            end
        end
        chk("t1_event_cyc", ev_at, 5);
        chk("t1_resetA_len", n_ra, RCYC);
        chk("t1_busy_len", n_bz, RCYC + GCYC);
        chk("t1_busy_last", last_bz, 4 + RCYC + GCYC);
        chk("t1_switch", switch, 1'b1);

        // 2: commanded switch, both healthy
        do_reset();
        command(1'b1);
        chk("t2_switch", switch, 1'b1);
        chk("t2_no_reset", {reset_A, reset_B}, 2'b00);
        n_bz = busy ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (busy) n_bz++;
        end
        chk("t2_busy_len", n_bz, GCYC);
        command(1'b0);
        chk("t2_back", switch, 1'b0);
        steps(20);

        // 3: command to unhealthy standby, then forced
        do_reset();
        io_b = 1'b0;
        steps(6);
        command(1'b1);
        chk("t3_reject", cmd_reject, 1'b1);
        chk("t3_stay", switch, 1'b0);
        force_swi = 1'b1;
        step();
        command(1'b1);
        chk("t3_forced", switch, 1'b1);
        steps(20);

        // 4: double fault, then B recovers
        do_reset();
        io_a = 1'b0; io_b = 1'b0;
        steps(5);
        chk("t4_fault", fault, 1'b1);
        chk("t4_stay", switch, 1'b0);
        io_b = 1'b1;
        steps(5);
        chk("t4_to_b", switch, 1'b1);
        chk("t4_resetA", reset_A, 1'b1);
        steps(30);

        // 5: command during guard is dropped; rst aborts reset phase
        do_reset();
        command(1'b1);
        steps(3);
        command(1'b0);
        chk("t5_reject", cmd_reject, 1'b1);
        n_ev = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (swi_event) n_ev++;
        end
        chk("t5_no_switch", n_ev, 0);
        do_reset();
        io_a = 1'b0;
        steps(7);
        chk("t5_in_reset", reset_A, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        io_a = 1'b1;
        chk("t5_rst_abort", {reset_A, switch}, 2'b00);
        steps(5);

`ifdef SWI_COUNT_EN
        // 6: saturating handover counter
        do_reset();
        for (int k = 0; k < 300; k++) begin
            command(~switch);
            wait_idle();
        end
        chk("t6_count_sat", swi_count, 8'd255);
`endif

        // random phase
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (io_a) io_a = ($urandom_range(0, 19) != 0);
            else      io_a = ($urandom_range(0, 5) == 0);
            if (io_b) io_b = ($urandom_range(0, 19) != 0);
            else      io_b = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) force_swi = ~force_swi;
            com_swi = ($urandom_range(0, 15) == 0);
            com_target = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        com_swi = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
